// File: rtl/sound_pkg.sv
// Shared definitions for the sound channels: volume codes, channel state and
// the silence level of the offset-binary mixer outputs.
package sound_pkg;

  localparam logic [1:0] VOL_MUTE    = 2'd0;
  localparam logic [1:0] VOL_FULL    = 2'd1;
  localparam logic [1:0] VOL_HALF    = 2'd2;
  localparam logic [1:0] VOL_QUARTER = 2'd3;

  typedef enum logic {
    CH_OFF = 1'b0,
    CH_RUN = 1'b1
  } ch_state_e;

  // Silence level for an offset-binary output of the given width.
  function automatic int unsigned mid(input int unsigned out_w);
    return (32'd1 << (out_w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/sound_wave_channel_if.sv
// CPU-side wave RAM bus of the wave channel: byte write strobe, address,
// write data and combinational readback.
interface sound_wave_channel_if #(
  parameter int AW = 4
);
  logic          iWaveWe;
  logic [AW-1:0] iWaveAddr;
  logic [7:0]    iWaveData;
  logic [7:0]    oWaveData;

  modport master (output iWaveWe, iWaveAddr, iWaveData, input oWaveData);
  modport slave  (input iWaveWe, iWaveAddr, iWaveData, output oWaveData);
endinterface

// File: rtl/sound_wave_ram.sv
// Byte-wide wave sample store: one write port, two combinational read ports
// (CPU readback and sample fetch), cleared by the asynchronous reset.
module sound_wave_ram #(
  parameter int RAM_BYTES = 16,
  parameter int AW        = 4
) (
  input  logic          iClock,
  input  logic          iReset,
  input  logic          iWe,
  input  logic [AW-1:0] iAddr,
  input  logic [7:0]    iData,
  output logic [7:0]    oData,
  input  logic [AW-1:0] iFetchAddr,
  output logic [7:0]    oFetchData
);

  logic [7:0] mem_q [RAM_BYTES];

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      for (int i = 0; i < RAM_BYTES; i++) mem_q[i] <= '0;
    end else if (iWe) begin
      mem_q[iAddr] <= iData;
    end
  end

  // Both reads see the pre-write contents during a write cycle.
  assign oData      = mem_q[iAddr];
  assign oFetchData = mem_q[iFetchAddr];

endmodule

// File: rtl/sound_wave_channel.sv
// Wave-playback sound channel: steps through packed samples of the wave RAM on
// iTickWave strobes, with length timer, volume shift and DAC enable.
module sound_wave_channel
  import sound_pkg::*;
#(
  parameter int SAMPLE_W  = 4,
  parameter int RAM_BYTES = 16,
  parameter int FREQ_W    = 11,
  parameter int LEN_W     = 8,
  parameter int OUT_W     = 5
) (
  input  logic                 iClock,
  input  logic                 iReset,
  input  logic                 iTick256,
  input  logic                 iTickWave,
  input  logic [7:0]           iNR30,
  input  logic [7:0]           iNR31,
  input  logic [7:0]           iNR32,
  input  logic [7:0]           iNR33,
  input  logic [7:0]           iNR34,
  input  logic                 iTrigger,
  input  logic                 iLengthLoad,
  sound_wave_channel_if.slave  wave_bus,
  output logic [OUT_W-1:0]     oOut,
  output logic                 oChannelOn
);

  localparam int AW    = (RAM_BYTES > 1) ? $clog2(RAM_BYTES) : 1;
  localparam int NSAMP = RAM_BYTES * 8 / SAMPLE_W;
  localparam int SPB   = 8 / SAMPLE_W;
  localparam int PW    = (NSAMP > 1) ? $clog2(NSAMP) : 1;

  localparam logic [FREQ_W:0]  FULL_PERIOD = {1'b1, {FREQ_W{1'b0}}};
  localparam logic [FREQ_W:0]  TMR_ONE     = {{FREQ_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0]   FULL_LEN    = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0]   LEN_ONE     = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0] MID         = OUT_W'(mid(OUT_W));
  localparam logic [OUT_W-1:0] OFFS        = MID - OUT_W'(2 ** (SAMPLE_W - 1));

  // First sample of a byte sits in its most significant bits.
  function automatic logic [SAMPLE_W-1:0] pick(input logic [7:0] b, input logic [PW-1:0] p);
    logic [7:0] sh;
    sh = b >> (SAMPLE_W * (SPB - 1 - (int'(p) % SPB)));
    return sh[SAMPLE_W-1:0];
  endfunction

  ch_state_e           state_q, state_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic [SAMPLE_W-1:0] buf_q, buf_d;
  logic [FREQ_W:0]     tmr_q, tmr_d;
  logic [LEN_W:0]      len_q, len_d;
  logic [OUT_W-1:0]    out_q, out_d;

  logic [10:0]         freq_raw;
  logic [FREQ_W:0]     period;
  logic [PW-1:0]       pos_nxt;
  logic [AW-1:0]       play_addr, cpu_addr, fetch_addr;
  logic [7:0]          fetch_byte;
  logic [1:0]          vol;
  logic [SAMPLE_W-1:0] scaled;
  logic                unused_bits;

  assign freq_raw   = {iNR34[2:0], iNR33};
  assign period     = FULL_PERIOD - {1'b0, FREQ_W'(freq_raw)};
  assign pos_nxt    = (pos_q == PW'(NSAMP - 1)) ? '0 : pos_q + PW'(1);
  assign play_addr  = AW'(pos_q / PW'(SPB));
  assign fetch_addr = AW'(pos_nxt / PW'(SPB));
  assign vol        = iNR32[6:5];
  assign unused_bits = ^{iNR30[6:0], iNR32[7], iNR32[4:0], iNR34[7], iNR34[5:3]};

  // While playing, the CPU only ever reaches the byte under the play head.
  assign cpu_addr = (state_q == CH_RUN) ? play_addr : wave_bus.iWaveAddr;

  sound_wave_ram #(
    .RAM_BYTES (RAM_BYTES),
    .AW        (AW)
  ) u_ram (
    .iClock     (iClock),
    .iReset     (iReset),
    .iWe        (wave_bus.iWaveWe),
    .iAddr      (cpu_addr),
    .iData      (wave_bus.iWaveData),
    .oData      (wave_bus.oWaveData),
    .iFetchAddr (fetch_addr),
    .oFetchData (fetch_byte)
  );

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    buf_d   = buf_q;
    tmr_d   = tmr_q;
    len_d   = len_q;

    if (state_q == CH_RUN && iTickWave) begin
      if (tmr_q == TMR_ONE) begin
        tmr_d = period;
        pos_d = pos_nxt;
        buf_d = pick(fetch_byte, pos_nxt);
      end else begin
        tmr_d = tmr_q - TMR_ONE;
      end
    end

    // Trigger owns the length counter on its cycle; load beats a tick.
    if (iTrigger) begin
      if (len_q == '0) len_d = FULL_LEN;
    end else if (iLengthLoad) begin
      len_d = FULL_LEN - {1'b0, LEN_W'(iNR31)};
    end else if (iTick256 && iNR34[6] && len_q != '0) begin
      len_d = len_q - LEN_ONE;
      if (len_q == LEN_ONE) state_d = CH_OFF;
    end

    if (!iNR30[7]) state_d = CH_OFF;

    if (iTrigger && iNR30[7]) begin
      state_d = CH_RUN;
      pos_d   = '0;
      buf_d   = '0;
      tmr_d   = period;
    end

    case (vol)
      VOL_FULL:    scaled = buf_q;
      VOL_HALF:    scaled = buf_q >> 1;
      VOL_QUARTER: scaled = buf_q >> 2;
      default:     scaled = '0;
    endcase

    out_d = (state_q == CH_RUN && vol != VOL_MUTE) ? OFFS + OUT_W'(scaled) : MID;
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q <= CH_OFF;
      pos_q   <= '0;
      buf_q   <= '0;
      tmr_q   <= '0;
      len_q   <= '0;
      out_q   <= MID;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      buf_q   <= buf_d;
      tmr_q   <= tmr_d;
      len_q   <= len_d;
      out_q   <= out_d;
    end
  end

  assign oOut       = out_q;
  assign oChannelOn = (state_q == CH_RUN);

endmodule

// File: tb/tb_sound_wave_channel.sv
// Bench for sound_wave_channel: directed walk through the play/length/RAM
// behaviour, then randomized traffic scored against a behavioural model.
module tb_sound_wave_channel;
  import sound_pkg::*;

  localparam int RAM_BYTES = 16;
  localparam int AW        = 4;
  localparam int NSAMP     = 32;
  localparam int OUT_W     = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             t256 = 1'b0, twave = 1'b0, trig = 1'b0, lload = 1'b0;
  logic [7:0]       nr30 = '0, nr31 = '0, nr32 = '0, nr33 = '0, nr34 = '0;
  logic [OUT_W-1:0] dut_out;
  logic             dut_on;

  sound_wave_channel_if #(.AW(AW)) bus ();

  sound_wave_channel #(
    .SAMPLE_W (4), .RAM_BYTES (RAM_BYTES), .FREQ_W (11), .LEN_W (8), .OUT_W (OUT_W)
  ) dut (
    .iClock      (clk),
    .iReset      (rst_n),
    .iTick256    (t256),
    .iTickWave   (twave),
    .iNR30       (nr30),
    .iNR31       (nr31),
    .iNR32       (nr32),
    .iNR33       (nr33),
    .iNR34       (nr34),
    .iTrigger    (trig),
    .iLengthLoad (lload),
    .wave_bus    (bus),
    .oOut        (dut_out),
    .oChannelOn  (dut_on)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endfunction

  // Behavioural model: integers and an array, following the channel's rules.
  int m_ram [RAM_BYTES];
  int m_on, m_pos, m_buf, m_tmr, m_len, m_out;

  typedef struct { int out; int on; int rd; } exp_t;
  exp_t exp_q [$];

  task automatic model_reset();
    for (int i = 0; i < RAM_BYTES; i++) m_ram[i] = 0;
    m_on = 0; m_pos = 0; m_buf = 0; m_tmr = 0; m_len = 0; m_out = 15;
  endtask

  function automatic int m_addr();
    return m_on ? m_pos / 2 : int'(bus.iWaveAddr);
  endfunction

  function automatic int sample_at(int p);
    int b = m_ram[p / 2];
    return (p % 2 == 0) ? (b >> 4) : (b & 15);
  endfunction

  task automatic model_next();
    int per, vol, n_on, n_pos, n_buf, n_tmr, n_len, n_out;
    per = 2048 - ((int'(nr34[2:0]) << 8) + int'(nr33));
    vol = int'(nr32[6:5]);
    n_on = m_on; n_pos = m_pos; n_buf = m_buf; n_tmr = m_tmr; n_len = m_len;
    n_out = (m_on != 0 && vol != 0) ? 15 + (m_buf >> (vol - 1)) - 8 : 15;
    if (m_on != 0 && twave) begin
      if (m_tmr == 1) begin
        n_tmr = per;
        n_pos = (m_pos + 1) % NSAMP;
        n_buf = sample_at(n_pos);
      end else n_tmr = m_tmr - 1;
    end
    if (trig) begin
      if (m_len == 0) n_len = 256;
    end else if (lload) n_len = 256 - int'(nr31);
    else if (t256 && nr34[6] && m_len != 0) begin
      n_len = m_len - 1;
      if (n_len == 0) n_on = 0;
    end
    if (m_on != 0 && !nr30[7]) n_on = 0;
    if (trig && nr30[7]) begin
      n_on = 1; n_pos = 0; n_buf = 0; n_tmr = per;
    end
    if (bus.iWaveWe) m_ram[m_addr()] = int'(bus.iWaveData);
    m_on = n_on; m_pos = n_pos; m_buf = n_buf; m_tmr = n_tmr; m_len = n_len; m_out = n_out;
  endtask

  // One clock cycle with the inputs as currently driven; entered at posedge+1.
  task automatic step();
    exp_t e;
    if (!rst_n) model_reset();
    e.out = m_out; e.on = m_on; e.rd = m_ram[m_addr()];
    exp_q.push_back(e);
    if (rst_n) model_next();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input int d);
    bus.iWaveWe = 1'b1; bus.iWaveAddr = AW'(a); bus.iWaveData = 8'(d);
    step();
    bus.iWaveWe = 1'b0;
  endtask

  task automatic pulse_trig();
    trig = 1'b1; step(); trig = 1'b0;
  endtask

  // Monitor: scores every cycle's outputs against the queued model values.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_oOut", int'(dut_out), e.out);
        chk("sb_oChannelOn", int'(dut_on), e.on);
        chk("sb_oWaveData", int'(bus.oWaveData), e.rd);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bus.iWaveWe = 1'b0; bus.iWaveAddr = '0; bus.iWaveData = '0;
    model_reset();
    @(posedge clk); #1;
    step(); step();
    chk("reset_oOut", int'(dut_out), 15);
    chk("reset_on", int'(dut_on), 0);
    chk("reset_ram0", int'(bus.oWaveData), 0);
    rst_n = 1'b1; step();

    wr(0, 8'h01); wr(1, 8'h23);
    bus.iWaveAddr = 4'd0; step();
    chk("rd_byte0", int'(bus.oWaveData), 8'h01);
    bus.iWaveAddr = 4'd1; step();
    chk("rd_byte1", int'(bus.oWaveData), 8'h23);
    chk("off_oOut", int'(dut_out), 15);
    chk("off_on", int'(dut_on), 0);

    nr30 = 8'h80; nr32 = 8'h20; nr33 = 8'hFF; nr34 = 8'h07;
    pulse_trig();
    chk("trig_on", int'(dut_on), 1);
    step();
    chk("play_pos0", int'(dut_out), 7);
    twave = 1'b1; step(); twave = 1'b0; step();
    chk("play_pos1", int'(dut_out), 8);
    twave = 1'b1; step(); twave = 1'b0; step();
    chk("play_pos2", int'(dut_out), 9);
    twave = 1'b1; step(); twave = 1'b0; step();
    chk("play_pos3", int'(dut_out), 10);
    nr32 = 8'h40; step(); chk("vol_half", int'(dut_out), 8);
    nr32 = 8'h60; step(); chk("vol_quarter", int'(dut_out), 7);
    nr32 = 8'h00; step(); chk("vol_mute", int'(dut_out), 15);
    nr32 = 8'h20; step(); chk("vol_full", int'(dut_out), 10);

    wr(5, 8'hAB);
    nr30 = 8'h00; step();
    chk("dac_off", int'(dut_on), 0);
    bus.iWaveAddr = 4'd1; step(); chk("redirect_b1", int'(bus.oWaveData), 8'hAB);
    bus.iWaveAddr = 4'd5; step(); chk("redirect_b5", int'(bus.oWaveData), 0);

    nr31 = 8'hFE; lload = 1'b1; step(); lload = 1'b0;
    nr30 = 8'h80; nr34 = 8'h47;
    pulse_trig();
    chk("len_start", int'(dut_on), 1);
    t256 = 1'b1; step(); t256 = 1'b0;
    chk("len_tick1", int'(dut_on), 1);
    t256 = 1'b1; step(); t256 = 1'b0;
    chk("len_tick2", int'(dut_on), 0);
    step();
    chk("len_silent", int'(dut_out), 15);

    trig = 1'b1; t256 = 1'b1; step(); trig = 1'b0;
    chk("trig_tick_on", int'(dut_on), 1);
    for (int i = 0; i < 255; i++) step();
    chk("full_len_255", int'(dut_on), 1);
    step(); t256 = 1'b0;
    chk("full_len_256", int'(dut_on), 0);

    wr(0, 8'h91);
    nr34 = 8'h07;
    pulse_trig();
    twave = 1'b1;
    for (int i = 0; i < NSAMP; i++) step();
    twave = 1'b0; step();
    chk("wrap_pos0", int'(dut_out), 16);

    rst_n = 1'b0; #2;
    chk("async_rst_out", int'(dut_out), 15);
    chk("async_rst_on", int'(dut_on), 0);
    bus.iWaveAddr = 4'd0; #1;
    chk("async_rst_ram", int'(bus.oWaveData), 0);
    step();
    rst_n = 1'b1; step();

    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      nr30  = ($urandom_range(0, 19) != 0) ? 8'h80 : 8'h00;
      nr31  = 8'($urandom_range(200, 255));
      nr32  = 8'($urandom);
      nr33  = 8'($urandom_range(240, 255));
      nr34  = {1'b0, 1'($urandom), 3'b000, 3'b111};
      trig  = ($urandom_range(0, 39) == 0);
      lload = ($urandom_range(0, 39) == 0);
      t256  = ($urandom_range(0, 7) == 0);
      twave = ($urandom_range(0, 1) == 0);
      bus.iWaveWe   = ($urandom_range(0, 4) == 0);
      bus.iWaveAddr = AW'($urandom);
      bus.iWaveData = 8'($urandom);
      step();
    end
    rst_n = 1'b1; trig = 1'b0; lload = 1'b0; t256 = 1'b0; twave = 1'b0; bus.iWaveWe = 1'b0;

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
